// File: rtl/uart_pkg.sv
// Shared definitions for the debug UART transmit path: FSM state
// encoding, 8N1 frame geometry and the default bit period.
package uart_pkg;

   // Transmitter phases; IDLE must stay the all-zero encoding.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } txState_t;

   localparam int DATA_BITS            = 8;
   localparam int STOP_BITS            = 1;
   // 50 MHz system clock / 115200 baud.
   localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-push and status bundle between the debug unit (master) and the
// UART transmitter (slave). Clock and reset travel as plain ports.
interface uart_tx_fifo_if #(
   parameter int FIFO_DEPTH_LOG2 = 4
);
   import uart_pkg::*;

   logic [DATA_BITS-1:0]     dataIn;
   logic                     writeFlag;
   logic                     notStartTrans;
   logic                     tx;
   logic                     dataSent;
   logic                     txBusy;
   logic                     fifoFull;
   logic                     fifoEmpty;
   logic [FIFO_DEPTH_LOG2:0] fifoCount;
   logic                     overflow;

   modport master (
      output dataIn, writeFlag, notStartTrans,
      input  tx, dataSent, txBusy, fifoFull, fifoEmpty, fifoCount, overflow
   );

   modport slave (
      input  dataIn, writeFlag, notStartTrans,
      output tx, dataSent, txBusy, fifoFull, fifoEmpty, fifoCount, overflow
   );

endinterface

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter. Storage is a plain
// array with a registered, read-first output so it maps onto block RAM;
// the popped byte appears on popData the cycle after the pop.
module byte_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [DATA_BITS-1:0]     dataIn,
   input  logic                     writeFlag,
   input  logic                     pop,
   output logic [DATA_BITS-1:0]     popData,
   output logic [FIFO_DEPTH_LOG2:0] fifoCount,
   output logic                     fifoFull,
   output logic                     fifoEmpty,
   output logic                     overflow
);

   localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
   localparam int COUNT_W = FIFO_DEPTH_LOG2 + 1;
   localparam logic [COUNT_W-1:0] DEPTH_COUNT = COUNT_W'(DEPTH);

   logic [DATA_BITS-1:0]       mem [DEPTH];
   logic [DATA_BITS-1:0]       popDataReg;
   logic [FIFO_DEPTH_LOG2-1:0] wrPtrReg;
   logic [FIFO_DEPTH_LOG2-1:0] rdPtrReg;
   logic [COUNT_W-1:0]         countReg;
   logic                       overflowReg;
   logic                       doPop;
   logic                       doWrite;

   // Flags decode straight from the registered count.
   assign fifoFull  = (countReg == DEPTH_COUNT);
   assign fifoEmpty = (countReg == '0);

   // A pop in the same cycle frees a slot, so a write at full is still legal.
   assign doPop   = pop && !fifoEmpty;
   assign doWrite = writeFlag && (!fifoFull || doPop);

   assign popData   = popDataReg;
   assign fifoCount = countReg;
   assign overflow  = overflowReg;

   // Storage write port; no reset so the array stays RAM-mappable.
   always_ff @(posedge clock) begin
      if (reset && doWrite) begin
         mem[wrPtrReg] <= dataIn;
      end
   end

   // Registered read port; read-first, so push+pop at full returns the old head.
   always_ff @(posedge clock) begin
      if (doPop) begin
         popDataReg <= mem[rdPtrReg];
      end
   end

   // Pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wrPtrReg    <= '0;
         rdPtrReg    <= '0;
         countReg    <= '0;
         overflowReg <= 1'b0;
      end else begin
         if (doWrite) begin
            wrPtrReg <= wrPtrReg + FIFO_DEPTH_LOG2'(1);
         end
         if (doPop) begin
            rdPtrReg <= rdPtrReg + FIFO_DEPTH_LOG2'(1);
         end
         case ({doWrite, doPop})
            2'b10:   countReg <= countReg + COUNT_W'(1);
            2'b01:   countReg <= countReg - COUNT_W'(1);
            default: countReg <= countReg;
         endcase
         if (writeFlag && !doWrite) begin
            overflowReg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Debug UART transmitter: queues bytes from the debug unit in byte_fifo
// and sends them as 8N1 frames, pulsing dataSent during each final stop
// bit cycle. tx, txBusy and dataSent are all registered.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input logic           clock,
   input logic           reset,
   uart_tx_fifo_if.slave bus
);

   localparam int BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam int BIT_IDX_W = $clog2(DATA_BITS);
   localparam logic [BAUD_W-1:0]    BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0]    BAUD_PENULT   = BAUD_W'(CLKS_PER_BIT - 2);
   localparam logic [BIT_IDX_W-1:0] LAST_DATA_IDX = BIT_IDX_W'(DATA_BITS - 1);
   localparam logic [BIT_IDX_W-1:0] LAST_STOP_IDX = BIT_IDX_W'(STOP_BITS - 1);

   txState_t               stateReg, stateNext;
   logic [BAUD_W-1:0]      baudReg, baudNext;
   logic [BIT_IDX_W-1:0]   bitIdxReg, bitIdxNext;
   logic [DATA_BITS-1:0]   shiftReg, shiftNext;
   logic                   txReg, txNext;
   logic                   dataSentReg, dataSentNext;
   logic                   txBusyReg, txBusyNext;
   logic                   baudDone;
   logic                   pop;
   logic [DATA_BITS-1:0]   popData;
   logic                   fifoEmpty;
   logic                   fifoFull;
   logic [FIFO_DEPTH_LOG2:0] fifoCount;
   logic                   overflow;

   byte_fifo #(
      .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) fifo (
      .clock     (clock),
      .reset     (reset),
      .dataIn    (bus.dataIn),
      .writeFlag (bus.writeFlag),
      .pop       (pop),
      .popData   (popData),
      .fifoCount (fifoCount),
      .fifoFull  (fifoFull),
      .fifoEmpty (fifoEmpty),
      .overflow  (overflow)
   );

   assign bus.tx        = txReg;
   assign bus.dataSent  = dataSentReg;
   assign bus.txBusy    = txBusyReg;
   assign bus.fifoFull  = fifoFull;
   assign bus.fifoEmpty = fifoEmpty;
   assign bus.fifoCount = fifoCount;
   assign bus.overflow  = overflow;

   assign baudDone = (baudReg == BAUD_LAST);

   // Next state, bit timing and registered-output values for the frame FSM.
   // The FIFO read is registered, so the popped byte is taken from popData
   // at the end of the start bit rather than in IDLE; tx is unaffected.
   always_comb begin
      stateNext    = stateReg;
      baudNext     = baudReg;
      bitIdxNext   = bitIdxReg;
      shiftNext    = shiftReg;
      txNext       = 1'b1;
      dataSentNext = 1'b0;
      pop          = 1'b0;

      case (stateReg)
         IDLE: begin
            baudNext   = '0;
            bitIdxNext = '0;
            if (!fifoEmpty && !bus.notStartTrans) begin
               pop       = 1'b1;
               stateNext = START;
               txNext    = 1'b0;
            end
         end

         START: begin
            txNext   = 1'b0;
            baudNext = baudDone ? '0 : baudReg + BAUD_W'(1);
            if (baudDone) begin
               stateNext  = DATA;
               shiftNext  = popData;
               bitIdxNext = '0;
               txNext     = popData[0];
            end
         end

         DATA: begin
            txNext   = shiftReg[0];
            baudNext = baudDone ? '0 : baudReg + BAUD_W'(1);
            if (baudDone) begin
               if (bitIdxReg == LAST_DATA_IDX) begin
                  stateNext  = STOP;
                  bitIdxNext = '0;
                  txNext     = 1'b1;
               end else begin
                  shiftNext  = shiftReg >> 1;
                  bitIdxNext = bitIdxReg + BIT_IDX_W'(1);
                  txNext     = shiftReg[1];
               end
            end
         end

         STOP: begin
            txNext   = 1'b1;
            baudNext = baudDone ? '0 : baudReg + BAUD_W'(1);
            // Raise dataSent on the edge that enters the last stop-bit cycle.
            if (bitIdxReg == LAST_STOP_IDX && baudReg == BAUD_PENULT) begin
               dataSentNext = 1'b1;
            end
            if (baudDone) begin
               if (bitIdxReg == LAST_STOP_IDX) begin
                  stateNext  = IDLE;
                  bitIdxNext = '0;
               end else begin
                  bitIdxNext = bitIdxReg + BIT_IDX_W'(1);
               end
            end
         end

         default: begin
            stateNext = IDLE;
         end
      endcase

      txBusyNext = (stateNext != IDLE);
   end

   // Frame FSM state and registered outputs; reset aborts any frame in flight.
   always_ff @(posedge clock) begin
      if (!reset) begin
         stateReg    <= IDLE;
         baudReg     <= '0;
         bitIdxReg   <= '0;
         shiftReg    <= '0;
         txReg       <= 1'b1;
         dataSentReg <= 1'b0;
         txBusyReg   <= 1'b0;
      end else begin
         stateReg    <= stateNext;
         baudReg     <= baudNext;
         bitIdxReg   <= bitIdxNext;
         shiftReg    <= shiftNext;
         txReg       <= txNext;
         dataSentReg <= dataSentNext;
         txBusyReg   <= txBusyNext;
      end
   end

endmodule
